pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It generates PC and pipeline-register enables, flush and bubble controls for IF/ID, ID/EX, EX/MEM and MEM/WB. It handles load-use hazards, taken branches and jumps, data-memory wait states and an orderly halt drain. It sits beside the datapath, fed by decode (ID) and execute (EX) stage status, and drives the `stall` field that ID packs into its output struct.

Parameters:
- MAX_WAIT, 16: maximum consecutive MEM_WAIT cycles before a timeout error.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- idex_memRead  in  1  instruction in EX is a load
- idex_rd  in  5  destination register of the instruction in EX
- ex_redirect  in  1  taken branch or jump resolved in EX
- ex_halt  in  1  EBREAK/ECALL-halt present in EX
- dmem_req  in  1  EX/MEM instruction is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID register clears to NOP
- idex_flush  out  1  ID/EX register loads a bubble
- exmem_en  out  1  EX/MEM register enable
- memwb_en  out  1  MEM/WB register enable
- stall  out  1  load-use stall indicator, sent to the ID output
- halted  out  1  core is in HALT
- mem_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  count of load-use stall cycles
- flush_cnt  out  CNT_W  count of redirect flush events
- wait_cnt  out  CNT_W  count of MEM_WAIT cycles

Behaviour:
- State encoding: RUN, MEM_WAIT, DRAIN, HALT, held in a registered state register.
- Control outputs are combinational from the registered state and current inputs. Counters and flags are registered.
- While rst=1:
  - pc_en, ifid_en, exmem_en and memwb_en are 0.
  - ifid_flush and idex_flush are 1.
  - stall, halted and mem_timeout are 0; counters are 0.
  - Next state is RUN, and the wait timer is 0.
- Hazard detection: lu = idex_memRead & idex_rd≠0 & ((id_use_rs1 & id_rs1==idex_rd) | (id_use_rs2 & id_rs2==idex_rd)).
- RUN, priority highest first:
  1. dmem_req & !dmem_ready: all enables 0, no flushes. Next state MEM_WAIT, timer ← 1, wait_cnt++.
  2. ex_halt: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. Next state DRAIN, drain counter ← 2.
  3. ex_redirect: all enables 1, ifid_flush=1, idex_flush=1. flush_cnt++. Redirect wins over lu; stall=0.
  4. lu: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1, stall=1. stall_cnt++. This is a one-cycle bubble; the hazard clears naturally the next cycle.
  5. Otherwise: all enables 1, no flushes.
- MEM_WAIT:
  - All enables 0; redirect, lu and halt inputs are ignored (frozen).
  - dmem_ready=1: outputs are as RUN case 5 this cycle, next state RUN, timer ← 0.
  - Otherwise wait_cnt++ and timer++.
  - When timer reaches MAX_WAIT with ready still 0: mem_timeout ← 1 (sticky), next state HALT.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. dmem wait takes priority and holds the drain counter.
  - Drain counter decrements each advancing cycle; at 0, next state HALT.
- HALT: halted=1, all enables 0, no flushes. Exits only on rst.
- Counters saturate at all-ones (no wrap).
- Reset mid-MEM_WAIT or mid-DRAIN returns to RUN the next cycle with counters cleared.

Decomposition:
- Add to struct_pkg:
  - `hz_ctrl_t` packed struct {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en, stall}.
  - `ctrl_state_e` enum.
  - Localparams for the halt opcode/funct.
- Existing `idex_t` supplies the idex_rd/idex_memRead fields.
- One sub-module, `sat_counter` (parameterised CNT_W, inc, clr), instantiated three times.

Test Plan:
- Load-use: idex_memRead=1, idex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1, stall=1 that cycle; next cycle all enables 1; stall_cnt=1.
- Redirect with simultaneous lu (rd=5/rs1=5) → ifid_flush=1, idex_flush=1, pc_en=1, stall=0; flush_cnt=1, stall_cnt=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 → enables 0 for 3 cycles, all 1 on the ready cycle; wait_cnt=3, state RUN.
- Timeout with MAX_WAIT=4: dmem_ready held 0 → mem_timeout=1 after 4 wait cycles, halted=1 next cycle; later ready=1 has no effect.
- Halt drain: ex_halt=1 → exmem_en/memwb_en=1 for 2 cycles with pc_en=0, then halted=1; rst=1 → pc_en=0 and flushes=1 during reset, RUN with counters 0 after.
- Reset mid-MEM_WAIT (cycle 2): state RUN, wait_cnt=0, mem_timeout=0 after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   hz_ctrl_t    : bundle of pipeline-register controls driven by the sequencer
//   ctrl_state_e : sequencer states
//   idex_t       : ID/EX fields the hazard check needs
//   Halt opcode/funct constants used by decode to raise ex_halt.
package pipe_hazard_ctrl_pkg;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic stall;
  } hz_ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_DRAIN,
    ST_HALT
  } ctrl_state_e;

  typedef struct packed {
    logic       mem_read;
    logic [4:0] rd;
  } idex_t;

  // SYSTEM opcode with ECALL/EBREAK funct12 encodings.
  localparam logic [6:0]  OPC_SYSTEM     = 7'b1110011;
  localparam logic [2:0]  FUNCT3_PRIV    = 3'b000;
  localparam logic [11:0] FUNCT12_ECALL  = 12'h000;
  localparam logic [11:0] FUNCT12_EBREAK = 12'h001;

  // Control presets.
  localparam hz_ctrl_t CTRL_FROZEN = '{default: 1'b0};
  localparam hz_ctrl_t CTRL_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                       idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1,
                                       stall: 1'b0};
  localparam hz_ctrl_t CTRL_REDIR  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                       idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                       stall: 1'b0};
  // Front end held, bubble into EX, back end keeps draining.
  localparam hz_ctrl_t CTRL_BUBBLE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                       idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                       stall: 1'b0};
  localparam hz_ctrl_t CTRL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                       idex_flush: 1'b1, exmem_en: 1'b0, memwb_en: 1'b0,
                                       stall: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter.
//   clk   : clock
//   clr   : synchronous clear (highest priority)
//   inc   : add one this cycle, holds at all-ones
//   count : current value
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                              count_d = '0;
    else if (inc && (count_q != '1))      count_d = count_q + 1'b1;
  end

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) count_q <= count_d;

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: PC / pipeline-register enables,
// flush and bubble controls, load-use stalls, redirects, data-memory waits
// with timeout, and an orderly drain into HALT.
//   Inputs : ID operand info, ID/EX load info, EX redirect/halt, dmem handshake
//   Outputs: pc_en, ifid_en/flush, idex_flush, exmem_en, memwb_en, stall,
//            halted, mem_timeout, stall/flush/wait performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             idex_memRead,
  input  logic [4:0]       idex_rd,
  input  logic             ex_redirect,
  input  logic             ex_halt,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             stall,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int TIMER_W = $clog2(MAX_WAIT + 1);

  ctrl_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         drain_q, drain_d;
  logic               mem_timeout_q, mem_timeout_d;

  idex_t      idex;
  hz_ctrl_t   ctrl;
  logic       lu, dmem_wait;
  logic       stall_inc, flush_inc, wait_inc;
  logic [CNT_W-1:0] stall_raw, flush_raw, wait_raw;

  assign idex      = '{mem_read: idex_memRead, rd: idex_rd};
  assign dmem_wait = dmem_req & ~dmem_ready;

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign lu = idex.mem_read && (idex.rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == idex.rd)) ||
               (id_use_rs2 && (id_rs2 == idex.rd)));

  // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ctrl          = CTRL_FROZEN;
    state_d       = state_q;
    timer_d       = timer_q;
    drain_d       = drain_q;
    mem_timeout_d = mem_timeout_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    wait_inc      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (dmem_wait) begin
          state_d  = ST_MEM_WAIT;
          timer_d  = TIMER_W'(1);
          wait_inc = 1'b1;
        end else if (ex_halt) begin
          ctrl    = CTRL_BUBBLE;
          state_d = ST_DRAIN;
          drain_d = 2'd2;
        end else if (ex_redirect) begin
          ctrl      = CTRL_REDIR;
          flush_inc = 1'b1;
        end else if (lu) begin
          ctrl       = CTRL_BUBBLE;
          ctrl.stall = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          ctrl = CTRL_RUN;
        end
      end

      // Whole pipe frozen; EX-stage requests are re-seen once RUN resumes.
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          ctrl    = CTRL_RUN;
          state_d = ST_RUN;
          timer_d = '0;
        end else begin
          wait_inc = 1'b1;
          timer_d  = timer_q + 1'b1;
          // This cycle's increment brings the timer to MAX_WAIT.
          if (timer_q == TIMER_W'(MAX_WAIT - 1)) begin
            mem_timeout_d = 1'b1;
            state_d       = ST_HALT;
          end
        end
      end

      ST_DRAIN: begin
        if (!dmem_wait) begin
          ctrl    = CTRL_BUBBLE;
          drain_d = drain_q - 2'd1;
          if (drain_q == 2'd1) state_d = ST_HALT;
        end
      end

      ST_HALT: ;

      default: state_d = ST_RUN;
    endcase

    if (rst) begin
      ctrl      = CTRL_RESET;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      wait_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      timer_q       <= '0;
      drain_q       <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      drain_q       <= drain_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .clr(rst), .inc(stall_inc), .count(stall_raw));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .clr(rst), .inc(flush_inc), .count(flush_raw));
  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt  (.clk(clk), .clr(rst), .inc(wait_inc),  .count(wait_raw));

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign stall       = ctrl.stall;
  // Status outputs read as cleared for the whole reset window.
  assign halted      = (state_q == ST_HALT) && !rst;
  assign mem_timeout = mem_timeout_q && !rst;
  assign stall_cnt   = rst ? '0 : stall_raw;
  assign flush_cnt   = rst ? '0 : flush_raw;
  assign wait_cnt    = rst ? '0 : wait_raw;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a behavioural model checked every
// cycle on the falling edge, plus hand-computed directed expectations.
module tb_pipe_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, idex_rd;
  logic             id_use_rs1, id_use_rs2, idex_memRead;
  logic             ex_redirect, ex_halt, dmem_req, dmem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en;
  logic             stall, halted, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .idex_memRead(idex_memRead), .idex_rd(idex_rd),
    .ex_redirect(ex_redirect), .ex_halt(ex_halt),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .stall(stall), .halted(halted),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks what the pipeline is doing in plain terms: how long the current
  // memory wait has lasted, how many drain steps remain, whether halted.
  int m_wait_len   = 0;   // 0: no memory wait in progress
  int m_drain_left = 0;   // 0: not draining
  bit m_halted     = 0;
  bit m_timeout    = 0;
  int m_stall_n = 0, m_flush_n = 0, m_wait_n = 0;

  function automatic int sat_inc(input int n);
    return (n < CNT_MAX) ? n + 1 : n;
  endfunction

  // ctrl vector order: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en, stall}
  always @(negedge clk) begin : model
    logic [6:0] e;
    bit e_halted, e_to, lu, dwait;
    lu = idex_memRead && (idex_rd != 5'd0) &&
         ((id_use_rs1 && id_rs1 == idex_rd) || (id_use_rs2 && id_rs2 == idex_rd));
    dwait    = dmem_req && !dmem_ready;
    e_halted = 1'b0;
    e_to     = rst ? 1'b0 : m_timeout;

    check("model stall_cnt", 32'(stall_cnt), rst ? 0 : m_stall_n);
    check("model flush_cnt", 32'(flush_cnt), rst ? 0 : m_flush_n);
    check("model wait_cnt",  32'(wait_cnt),  rst ? 0 : m_wait_n);
    check("model mem_timeout", 32'(mem_timeout), 32'(e_to));

    if (rst) begin
      e = 7'b0011000;
      m_wait_len = 0; m_drain_left = 0; m_halted = 0; m_timeout = 0;
      m_stall_n = 0; m_flush_n = 0; m_wait_n = 0;
    end else if (m_halted) begin
      e = 7'b0000000;
      e_halted = 1'b1;
    end else if (m_wait_len > 0) begin
      if (dmem_ready) begin
        e = 7'b1100110;
        m_wait_len = 0;
      end else begin
        e = 7'b0000000;
        m_wait_n = sat_inc(m_wait_n);
        m_wait_len++;
        if (m_wait_len == MAX_WAIT) begin
          m_timeout = 1; m_halted = 1; m_wait_len = 0;
        end
      end
    end else if (m_drain_left > 0) begin
      if (dwait) e = 7'b0000000;
      else begin
        e = 7'b0001110;
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end
    end else if (dwait) begin
      e = 7'b0000000;
      m_wait_len = 1;
      m_wait_n = sat_inc(m_wait_n);
    end else if (ex_halt) begin
      e = 7'b0001110;
      m_drain_left = 2;
    end else if (ex_redirect) begin
      e = 7'b1111110;
      m_flush_n = sat_inc(m_flush_n);
    end else if (lu) begin
      e = 7'b0001111;
      m_stall_n = sat_inc(m_stall_n);
    end else begin
      e = 7'b1100110;
    end

    check("model ctrl", 32'({pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en, stall}),
          32'(e));
    check("model halted", 32'(halted), 32'(e_halted));
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    idex_memRead = 1'b0; idex_rd = 5'd0;
    ex_redirect = 1'b0; ex_halt = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // Reset values.
    mid();
    check("rst pc_en", 32'(pc_en), 0);
    check("rst ifid_flush", 32'(ifid_flush), 1);
    check("rst idex_flush", 32'(idex_flush), 1);
    next_cycle();
    rst = 1'b0;
    mid();
    check("post-rst all enables", 32'({pc_en, ifid_en, exmem_en, memwb_en}), 32'hF);
    check("post-rst stall_cnt", 32'(stall_cnt), 0);
    next_cycle();

    // Load-use on rs2.
    idex_memRead = 1'b1; idex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    mid();
    check("lu pc/ifid/idexfl/stall", 32'({pc_en, ifid_en, idex_flush, stall}), 32'b0011);
    next_cycle();
    idle();
    mid();
    check("lu after enables", 32'({pc_en, ifid_en, exmem_en, memwb_en}), 32'hF);
    check("lu stall_cnt", 32'(stall_cnt), 1);
    next_cycle();

    // Load to x0 and an unused matching operand never stall.
    idex_memRead = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    mid();
    check("rd0 no stall", 32'({pc_en, stall}), 32'b10);
    next_cycle();
    idex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
    mid();
    check("unused rs1 no stall", 32'({pc_en, stall}), 32'b10);
    next_cycle();

    // Redirect beats a simultaneous load-use.
    do_reset();
    idex_memRead = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
    mid();
    check("redir ifid/idex flush, pc, stall", 32'({ifid_flush, idex_flush, pc_en, stall}), 32'b1110);
    next_cycle();
    idle();
    mid();
    check("redir flush_cnt", 32'(flush_cnt), 1);
    check("redir stall_cnt", 32'(stall_cnt), 0);
    next_cycle();

    // Three wait cycles then ready.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("wait enables off", 32'({pc_en, ifid_en, exmem_en, memwb_en}), 0);
      next_cycle();
    end
    dmem_ready = 1'b1;
    mid();
    check("ready enables on", 32'({pc_en, ifid_en, exmem_en, memwb_en}), 32'hF);
    next_cycle();
    idle();
    mid();
    check("wait_cnt 3", 32'(wait_cnt), 3);
    check("back in RUN", 32'({pc_en, halted, mem_timeout}), 32'b100);
    next_cycle();

    // Timeout after MAX_WAIT wait cycles; ready afterwards is ignored.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      mid();
      check("pre-timeout", 32'({pc_en, mem_timeout, halted}), 0);
      next_cycle();
    end
    mid();
    check("timeout flag/halted", 32'({mem_timeout, halted}), 32'b11);
    check("timeout wait_cnt", 32'(wait_cnt), 4);
    next_cycle();
    dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      check("halt ignores ready", 32'({halted, pc_en, exmem_en}), 32'b100);
      next_cycle();
    end

    // Halt drain with a memory stall in the middle, then reset out of HALT.
    do_reset();
    ex_halt = 1'b1;
    mid();
    check("halt cycle", 32'({pc_en, ifid_en, idex_flush, exmem_en, memwb_en}), 32'b00111);
    next_cycle();
    ex_halt = 1'b0;
    mid();
    check("drain 1", 32'({pc_en, exmem_en, memwb_en, halted}), 32'b0110);
    next_cycle();
    dmem_req = 1'b1;
    mid();
    check("drain held by wait", 32'({exmem_en, memwb_en, halted}), 0);
    next_cycle();
    dmem_req = 1'b0;
    mid();
    check("drain 2", 32'({pc_en, exmem_en, memwb_en, halted}), 32'b0110);
    next_cycle();
    mid();
    check("halted after drain", 32'({halted, exmem_en}), 32'b10);
    next_cycle();
    rst = 1'b1;
    mid();
    check("rst from HALT", 32'({pc_en, ifid_flush, idex_flush, halted}), 32'b0110);
    next_cycle();
    rst = 1'b0;
    mid();
    check("run after halt rst", 32'({halted, pc_en}), 32'b01);
    check("counters cleared", 32'({stall_cnt, flush_cnt, wait_cnt}), 0);
    next_cycle();

    // Reset during the second wait cycle.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    idle();
    mid();
    check("mid-wait rst RUN", 32'({pc_en, halted, mem_timeout}), 32'b100);
    check("mid-wait rst wait_cnt", 32'(wait_cnt), 0);
    next_cycle();

    // stall_cnt saturates at all-ones.
    do_reset();
    idex_memRead = 1'b1; idex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    for (int i = 0; i < CNT_MAX + 2; i++) next_cycle();
    idle();
    mid();
    check("stall_cnt saturates", 32'(stall_cnt), 7);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
